// File: rtl/gcd_stein_if.sv
// Start/done handshake bundle for the binary GCD unit.
// The requester drives the master side; the gcd_stein core sits on the slave side.
interface gcd_stein_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(4 * WIDTH + 8)
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, a_in, b_in,
        input  busy, done, result, cycles
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, result, cycles
    );
endinterface

// File: rtl/gcd_stein.sv
// Stein's binary GCD of two unsigned WIDTH-bit operands, using shifts and subtracts only.
// Every output is a register; a cycle counter reports latency from accept to done.
module gcd_stein #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(4 * WIDTH + 8)
) (
    input  logic       clk,
    input  logic       reset,
    gcd_stein_if.slave bus
);
    localparam int unsigned KW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StZchk,
        StStrip,
        StOdda,
        StLoop,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cycles;
    logic             r_busy;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_result <= '0;
            r_cycles <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (r_busy) begin
                r_cycles <= r_cycles + CNT_W'(1);
            end
            case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_a      <= bus.a_in;
                        r_b      <= bus.b_in;
                        r_k      <= '0;
                        r_cycles <= CNT_W'(1);
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= StZchk;
                    end
                end
                StZchk: begin
                    // gcd(0,0)=0 falls out of the a==0 branch, since result takes b.
                    if (r_a == '0) begin
                        r_result <= r_b;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else if (r_b == '0) begin
                        r_result <= r_a;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_state <= StStrip;
                    end
                end
                StStrip: begin
                    if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + KW'(1);
                    end else begin
                        r_state <= StOdda;
                    end
                end
                StOdda: begin
                    if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else begin
                        r_state <= StLoop;
                    end
                end
                StLoop: begin
                    // a stays odd here, so a swap-and-subtract always leaves b even.
                    if (r_b == '0) begin
                        r_result <= r_a << r_k;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a > r_b) begin
                        r_a <= r_b;
                        r_b <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cycles = r_cycles;
endmodule

// File: tb/tb_gcd_stein.sv
// Bench for gcd_stein: directed 32-bit cases, handshake and reset checks, then a random
// 8-bit sweep against a remainder-based GCD reference.
module tb_gcd_stein;
    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   max_cyc8 = 0;

    always #5 clk = ~clk;

    gcd_stein_if #(.WIDTH(32), .CNT_W(8)) bus32 ();
    gcd_stein_if #(.WIDTH(8),  .CNT_W(6)) bus8 ();

    gcd_stein #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    gcd_stein #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    function automatic longint unsigned gcd_ref(input longint unsigned a, input longint unsigned b);
        longint unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; counts edges from the accept edge until done is seen.
    task automatic wait_done32(input string tag, input longint unsigned exp, input int n0);
        int n = n0;
        while (!bus32.done && n < 4 * 32 + 12) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(bus32.done), 64'd1);
        chk({tag, "_result"}, 64'(bus32.result), 64'(exp));
        chk({tag, "_cycles"}, 64'(bus32.cycles), 64'(n));
        chk({tag, "_bound"}, 64'(n <= 4 * 32 + 4), 64'd1);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input string tag);
        bus32.start = 1'b1;
        bus32.a_in  = a;
        bus32.b_in  = b;
        @(negedge clk);
        bus32.start = 1'b0;
        bus32.a_in  = ~a;
        bus32.b_in  = ~b;
        chk({tag, "_busy"}, 64'(bus32.busy), 64'd1);
        chk({tag, "_dlow"}, 64'(bus32.done), 64'd0);
        wait_done32(tag, gcd_ref(64'(a), 64'(b)), 1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int n = 1;
        bus8.start = 1'b1;
        bus8.a_in  = a;
        bus8.b_in  = b;
        @(negedge clk);
        bus8.start = 1'b0;
        while (!bus8.done && n < 4 * 8 + 12) begin
            @(negedge clk);
            n++;
        end
        if (n > max_cyc8) max_cyc8 = n;
        chk("w8_done", 64'(bus8.done), 64'd1);
        chk("w8_result", 64'(bus8.result), gcd_ref(64'(a), 64'(b)));
        chk("w8_cycles", 64'(bus8.cycles), 64'(n));
    endtask

    initial begin
        reset       = 1'b1;
        bus32.start = 1'b0;
        bus32.a_in  = '0;
        bus32.b_in  = '0;
        bus8.start  = 1'b0;
        bus8.a_in   = '0;
        bus8.b_in   = '0;
        @(negedge clk);
        bus32.start = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(bus32.busy), 64'd0);
        chk("rst_done", 64'(bus32.done), 64'd0);
        chk("rst_result", 64'(bus32.result), 64'd0);
        chk("rst_cycles", 64'(bus32.cycles), 64'd0);
        chk("rst8_done", 64'(bus8.done), 64'd0);
        bus32.start = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        run32(32'd48, 32'd18, "basic");
        chk("basic_val", 64'(bus32.result), 64'd6);
        @(negedge clk);
        chk("basic_held", 64'(bus32.done), 64'd1);

        run32(32'd0, 32'd0, "z00");
        chk("z00_cyc", 64'(bus32.cycles), 64'd2);
        run32(32'd0, 32'd35, "z0b");
        chk("z0b_cyc", 64'(bus32.cycles), 64'd2);
        run32(32'd35, 32'd0, "za0");
        chk("za0_cyc", 64'(bus32.cycles), 64'd2);

        run32(32'd2147483648, 32'd1073741824, "pow2");
        chk("pow2_val", 64'(bus32.result), 64'd1073741824);
        run32(32'hFFFF_FFFF, 32'd1, "cop1");
        run32(32'd17, 32'd13, "cop2");
        for (int i = 0; i < 6; i++) begin
            run32($urandom, $urandom, "rnd32");
        end

        // A start pulse while busy must be dropped.
        bus32.start = 1'b1;
        bus32.a_in  = 32'd48;
        bus32.b_in  = 32'd18;
        @(negedge clk);
        bus32.start = 1'b0;
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.a_in  = 32'd100;
        bus32.b_in  = 32'd75;
        @(negedge clk);
        bus32.start = 1'b0;
        wait_done32("ign", 64'd6, 3);
        @(negedge clk);
        chk("ign_idle", 64'(bus32.busy), 64'd0);

        // Back-to-back: start issued in the cycle done is first seen.
        run32(32'd100, 32'd75, "b2b");
        run32(32'd100, 32'd75, "b2b2");

        bus32.start = 1'b1;
        bus32.a_in  = 32'hFFFF_FFFF;
        bus32.b_in  = 32'd1;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_busy", 64'(bus32.busy), 64'd0);
        chk("mid_done", 64'(bus32.done), 64'd0);
        chk("mid_result", 64'(bus32.result), 64'd0);
        chk("mid_cycles", 64'(bus32.cycles), 64'd0);
        repeat (3) @(negedge clk);
        chk("mid_quiet", 64'(bus32.done), 64'd0);
        run32(32'd48, 32'd18, "post");

        run8(8'd255, 8'd1);
        run8(8'd128, 8'd128);
        run8(8'd0, 8'd0);
        run8(8'd1, 8'd255);
        run8(8'd192, 8'd64);
        for (int i = 0; i < 700; i++) begin
            run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        chk("w8_maxcyc", 64'(max_cyc8 <= 36), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
